rv_muldiv_unit: RTL and testbench
=================================

// Module: rv_muldiv_unit
// PURPOSE
//   Parametrised iterative RV32M/RV64M multiply/divide unit for the EX stage of the pipelined core.
//   Supersedes the fixed 32-bit multiply-only pipelined multiplier.
//   Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (selected by funct3) via a start/busy/done handshake.
//   The hazard unit holds ID/EX while busy_o=1; EX/MEM captures result_o/rd_o on done_o.
// PARAMETERS
//   XLEN    32  operand/result width; must be 32 or 64
//   UNROLL  1   quotient/product bits resolved per CALC cycle; must be 1, 2 or 4 and divide XLEN
// PORTS
//   clk       in   1     clock, rising edge
//   rst       in   1     asynchronous, active-high reset
//   start_i   in   1     request; sampled only while busy_o=0
//   funct3_i  in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//   op_a_i    in   XLEN  rs1 value, already forwarded
//   op_b_i    in   XLEN  rs2 value, already forwarded
//   rd_i      in   5     destination register tag
//   flush_i   in   1     abort the in-flight operation (branch mispredict / pipeline flush)
//   busy_o    out  1     operation in flight; stall request to the hazard unit
//   done_o    out  1     one-cycle pulse; result_o/rd_o valid
//   result_o  out  XLEN  result; held until the next accepted start
//   rd_o      out  5     tag of the operation that produced result_o
// BEHAVIOUR
//   Reset: state=IDLE; busy_o=0, done_o=0, result_o=0, rd_o=0; all internal registers 0.
//   FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   - IDLE: on start_i=1, latch funct3_i and rd_i, and latch |op_a| and |op_b| per signedness
//     (MULH/DIV/REM: both signed; MULHSU: a signed, b unsigned).
//     Record the result sign. busy_o=1 from the next cycle.
//   - CALC: N=XLEN/UNROLL cycles.
//     - Multiply: shift-add into a 2*XLEN accumulator.
//     - Divide: restoring shift-subtract; quotient and remainder each XLEN wide.
//   - FIX: apply two's-complement negation where required.
//     - Product sign = sa^sb. Quotient sign = sa^sb. Remainder takes the dividend's sign.
//     - Select low half (MUL) or high half (MULH*), quotient (DIV*) or remainder (REM*).
//   - DONE: result_o/rd_o registered, done_o=1 for exactly one cycle, busy_o=0. Next state IDLE.
//     start_i in DONE is accepted exactly as in IDLE (back-to-back issue).
//   Latency: start accepted at edge k -> done_o high in cycle k+N+2 (N=32 -> 34 for defaults).
//   Special cases skip CALC and FIX (IDLE -> DONE; done_o in cycle k+1):
//   - divide by zero (op_b=0): DIV/DIVU -> all ones; REM/REMU -> op_a.
//   - signed overflow (DIV/REM, op_a=1<<(XLEN-1), op_b=-1): DIV -> op_a; REM -> 0.
//   Handshake and boundary rules:
//   - start_i while busy_o=1 is ignored; no queueing.
//   - flush_i=1 in any state -> IDLE next cycle; done_o is not asserted; result_o/rd_o keep their old values.
//     flush_i and start_i in the same cycle: flush wins and the start is dropped.
//   - rst asserted mid-operation: immediate return to reset values; no done_o.
//   - Operands are not re-sampled after acceptance; forwarding changes during CALC have no effect.
// CONFIGURATION
//   RV_MULDIV_FAST_MUL_EN defined:
//   - Multiplies compute the full 2*XLEN signed/unsigned product in a single cycle (IDLE -> FIX -> DONE).
//   - done_o in cycle k+2.
//   - Divides are unchanged.
//   Not defined:
//   - Multiplies use the iterative CALC path with N+2 latency.
//   - No combinational multiplier is inferred.
// TESTING (XLEN=32, UNROLL=1 unless stated)
//   - Reset/idle: assert rst mid-CALC -> busy_o, done_o, result_o, rd_o all 0 next cycle.
//     No done_o follows before a new start.
//   - MUL 7*-3, then MULHU ffffffff*ffffffff:
//     - first result ffffffeb, second result fffffffe.
//     - done_o 34 cycles after each start (2 cycles with RV_MULDIV_FAST_MUL_EN).
//   - MULH 80000000*80000000 -> 40000000. MULHSU ffffffff*ffffffff -> ffffffff.
//   - DIV -7/2 -> fffffffd; REM -7/2 -> ffffffff; DIVU 100/7 -> 0000000e; REMU 100/7 -> 00000002.
//     rd_o equals the issued tag each time.
//   - Edge cases, each with done_o 1 cycle after start:
//     - DIV 5/0 -> ffffffff
//     - REMU 5/0 -> 00000005
//     - DIV 80000000/ffffffff -> 80000000
//     - REM 80000000/ffffffff -> 0
//   - Handshake:
//     - start during busy is ignored; result is from the first op only.
//     - flush_i at CALC cycle 10 -> no done_o, result_o unchanged.
//     - start in the DONE cycle is accepted.
//     - UNROLL=4 divide -> done_o at start+10.

Source files
------------

// File: rtl/rv_muldiv_unit.sv
// -----------------------------------------------------------------------------
// rv_muldiv_unit
//   Iterative RV32M/RV64M multiply/divide unit for the EX stage.
//   Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (selected by funct3)
//   through a start/busy/done handshake.
//
//   Parameters
//     XLEN    operand/result width (32 or 64)
//     UNROLL  bits resolved per CALC cycle (1, 2 or 4; divides XLEN)
//
//   Ports
//     clk, rst    clock (rising edge), asynchronous active-high reset
//     start_i     request, sampled only while not busy (IDLE or DONE)
//     funct3_i    operation select
//     op_a_i      rs1 value
//     op_b_i      rs2 value
//     rd_i        destination register tag
//     flush_i     abort the in-flight operation, no done_o follows
//     busy_o      operation in flight (CALC/FIX)
//     done_o      one-cycle pulse, result_o/rd_o valid
//     result_o    result, held until the next completion
//     rd_o        tag of the operation that produced result_o
//
//   Configuration macro
//     RV_MULDIV_FAST_MUL_EN  multiplies use a single-cycle full-width product
//                            (IDLE -> FIX -> DONE); divides are unchanged.
//                            Undefined: multiplies run the iterative CALC path.
//
//   state | meaning
//   IDLE  | waiting for start_i
//   CALC  | N = XLEN/UNROLL shift-add / shift-subtract iterations
//   FIX   | sign correction and result selection
//   DONE  | result registered, done_o pulse; start_i accepted as in IDLE
// -----------------------------------------------------------------------------
module rv_muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam int N     = XLEN / UNROLL;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // hi/lo: product accumulator for multiply; remainder/quotient for divide
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    // multiplicand (multiply) or divisor (divide) magnitude
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        tag_q, tag_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_q, rd_d;

    // Operand decode for the request being offered
    logic              is_div_i;
    logic              a_signed, b_signed;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_by_zero, div_ovf;

    always_comb begin
        is_div_i    = funct3_i[2];
        a_signed    = is_div_i ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10);
        b_signed    = is_div_i ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01);
        a_neg       = a_signed & op_a_i[XLEN-1];
        b_neg       = b_signed & op_b_i[XLEN-1];
        abs_a       = a_neg ? -op_a_i : op_a_i;
        abs_b       = b_neg ? -op_b_i : op_b_i;
        div_by_zero = (op_b_i == '0);
        div_ovf     = ~funct3_i[0] && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
    end

    // UNROLL iterations of shift-add (multiply) or restoring shift-subtract (divide)
    logic [XLEN-1:0] step_hi, step_lo;
    logic [XLEN:0]   step_r;

    always_comb begin
        step_hi = hi_q;
        step_lo = lo_q;
        step_r  = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (f3_q[2]) begin
                step_r  = {step_hi, step_lo[XLEN-1]};
                step_lo = {step_lo[XLEN-2:0], 1'b0};
                if (step_r >= {1'b0, opnd_q}) begin
                    step_r     = step_r - {1'b0, opnd_q};
                    step_lo[0] = 1'b1;
                end
                step_hi = step_r[XLEN-1:0];
            end else begin
                step_r  = {1'b0, step_hi} + (step_lo[0] ? {1'b0, opnd_q} : '0);
                step_lo = {step_r[0], step_lo[XLEN-1:1]};
                step_hi = step_r[XLEN:1];
            end
        end
    end

    // Sign fix-up and result selection
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = (sa_q ^ sb_q) ? -prod : prod;
        quo_fix  = (sa_q ^ sb_q) ? -lo_q : lo_q;
        rem_fix  = sa_q ? -hi_q : hi_q;
        if (f3_q[2]) begin
            fix_result = f3_q[1] ? rem_fix : quo_fix;
        end else begin
            fix_result = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        f3_d     = f3_q;
        tag_d    = tag_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        rd_d     = rd_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    f3_d  = funct3_i;
                    tag_d = rd_i;
                    sa_d  = a_neg;
                    sb_d  = b_neg;
                    cnt_d = CNT_W'(N - 1);
                    if (is_div_i) begin
                        if (div_by_zero) begin
                            result_d = funct3_i[1] ? op_a_i : '1;
                            rd_d     = rd_i;
                            state_d  = S_DONE;
                        end else if (div_ovf) begin
                            result_d = funct3_i[1] ? '0 : op_a_i;
                            rd_d     = rd_i;
                            state_d  = S_DONE;
                        end else begin
                            hi_d    = '0;
                            lo_d    = abs_a;
                            opnd_d  = abs_b;
                            state_d = S_CALC;
                        end
                    end else begin
`ifdef RV_MULDIV_FAST_MUL_EN
                        {hi_d, lo_d} = (2*XLEN)'(abs_a) * (2*XLEN)'(abs_b);
                        opnd_d       = abs_a;
                        state_d      = S_FIX;
`else
                        hi_d    = '0;
                        lo_d    = abs_b;
                        opnd_d  = abs_a;
                        state_d = S_CALC;
`endif
                    end
                end
            end
            S_CALC: begin
                hi_d = step_hi;
                lo_d = step_lo;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                result_d = fix_result;
                rd_d     = tag_q;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush beats everything, including a start or completion this cycle
        if (flush_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
            rd_d     = rd_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            f3_q     <= '0;
            tag_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            f3_q     <= f3_d;
            tag_q    <= tag_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    assign busy_o   = (state_q == S_CALC) || (state_q == S_FIX);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
    assign rd_o     = rd_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
module tb_rv_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    logic        start4, flush4;
    logic [2:0]  funct3_4;
    logic [31:0] op_a4, op_b4;
    logic [4:0]  rd_in4;
    logic        busy4, done4;
    logic [31:0] result4;
    logic [4:0]  rd_out4;

    always #5 clk = ~clk;

    rv_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut (
        .clk(clk), .rst(rst), .start_i(start), .funct3_i(funct3),
        .op_a_i(op_a), .op_b_i(op_b), .rd_i(rd_in), .flush_i(flush),
        .busy_o(busy), .done_o(done), .result_o(result), .rd_o(rd_out)
    );

    rv_muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (
        .clk(clk), .rst(rst), .start_i(start4), .funct3_i(funct3_4),
        .op_a_i(op_a4), .op_b_i(op_b4), .rd_i(rd_in4), .flush_i(flush4),
        .busy_o(busy4), .done_o(done4), .result_o(result4), .rd_o(rd_out4)
    );

`ifdef RV_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] last_res;
    logic [4:0]  last_rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: RISC-V M-extension semantics using 64-bit host arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'd0: begin up = ua * ub;         r = up[31:0];  end
            3'd1: begin p  = sa * sb;         p = p >>> 32;  r = p[31:0]; end
            3'd2: begin p  = sa * longint'(ub); p = p >>> 32; r = p[31:0]; end
            3'd3: begin up = ua * ub;         r = up[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hffffffff;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 32'd0) ? 32'hffffffff : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int n);
        if (f[2] && (b == 32'd0)) return 1;
        if (f[2] && !f[0] && a == 32'h80000000 && b == 32'hffffffff) return 1;
        if (!f[2]) return (MUL_LAT == 2) ? 2 : n + 2;
        return n + 2;
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; rd_in = r; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // operands must not be re-sampled after acceptance
        op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
    endtask

    task automatic wait_done(output int cyc, output logic first_busy);
        cyc = 0;
        first_busy = 1'b0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) first_busy = busy;
            if (done) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r);
        logic [31:0] exp_res;
        int          exp_lat, cyc;
        logic        fb;
        exp_res = ref_op(f, a, b);
        exp_lat = ref_lat(f, a, b, 32);
        issue(f, a, b, r);
        wait_done(cyc, fb);
        check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_res"}, {32'b0, result}, {32'b0, exp_res});
        check({tag, "_rd"}, {59'b0, rd_out}, {59'b0, r});
        check({tag, "_busy1"}, {63'b0, fb}, {63'b0, exp_lat > 1});
        @(negedge clk);
        check({tag, "_pulse"}, {63'b0, done}, 64'd0);
        last_res = exp_res;
        last_rd  = r;
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int          cyc, nd;
        logic        fb;
        logic [2:0]  f;
        logic [31:0] a, b, e1, e2;
        int          sel;

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        start4 = 1'b0; flush4 = 1'b0; funct3_4 = '0; op_a4 = '0; op_b4 = '0; rd_in4 = '0;
        last_res = '0; last_rd = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_result", {32'b0, result}, 64'd0);
        check("rst_rd", {59'b0, rd_out}, 64'd0);
        rst = 1'b0;

        // Directed operations
        run_op("mul_7_m3",    3'd0, 32'd7,        32'hfffffffd, 5'd1);
        check("mul_7_m3_val", {32'b0, result}, 64'h00000000ffffffeb);
        run_op("mulhu_ff",    3'd3, 32'hffffffff, 32'hffffffff, 5'd2);
        check("mulhu_ff_val", {32'b0, result}, 64'h00000000fffffffe);
        run_op("mulh_min",    3'd1, 32'h80000000, 32'h80000000, 5'd3);
        check("mulh_min_val", {32'b0, result}, 64'h0000000040000000);
        run_op("mulhsu_ff",   3'd2, 32'hffffffff, 32'hffffffff, 5'd4);
        check("mulhsu_ff_val", {32'b0, result}, 64'h00000000ffffffff);
        run_op("div_m7_2",    3'd4, 32'hfffffff9, 32'd2,        5'd5);
        check("div_m7_2_val", {32'b0, result}, 64'h00000000fffffffd);
        run_op("rem_m7_2",    3'd6, 32'hfffffff9, 32'd2,        5'd6);
        check("rem_m7_2_val", {32'b0, result}, 64'h00000000ffffffff);
        run_op("divu_100_7",  3'd5, 32'd100,      32'd7,        5'd7);
        check("divu_100_7_val", {32'b0, result}, 64'h000000000000000e);
        run_op("remu_100_7",  3'd7, 32'd100,      32'd7,        5'd8);
        check("remu_100_7_val", {32'b0, result}, 64'h0000000000000002);
        run_op("div_5_0",     3'd4, 32'd5,        32'd0,        5'd9);
        check("div_5_0_val", {32'b0, result}, 64'h00000000ffffffff);
        run_op("remu_5_0",    3'd7, 32'd5,        32'd0,        5'd10);
        check("remu_5_0_val", {32'b0, result}, 64'h0000000000000005);
        run_op("div_ovf",     3'd4, 32'h80000000, 32'hffffffff, 5'd11);
        check("div_ovf_val", {32'b0, result}, 64'h0000000080000000);
        run_op("rem_ovf",     3'd6, 32'h80000000, 32'hffffffff, 5'd12);
        check("rem_ovf_val", {32'b0, result}, 64'h0000000000000000);

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h80000000; b = 32'hffffffff; end
            if (sel == 2) begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
            if (sel == 3) b = 32'($urandom_range(1, 1000));
            run_op("rand", f, a, b, 5'($urandom));
        end

        // Start while busy is ignored
        e1 = ref_op(3'd4, 32'd1000, 32'd3);
        issue(3'd4, 32'd1000, 32'd3, 5'd17);
        repeat (3) @(negedge clk);
        funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd18; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(cyc, fb);
        check("busy_ign_lat", 64'(cyc), 64'd31);
        check("busy_ign_res", {32'b0, result}, {32'b0, e1});
        check("busy_ign_rd", {59'b0, rd_out}, 64'd17);
        count_dones(60, nd);
        check("busy_ign_noqueue", 64'(nd), 64'd0);
        last_res = e1; last_rd = 5'd17;

        // Flush at CALC cycle 10
        issue(3'd5, 32'd123456, 32'd789, 5'd20);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", {63'b0, busy}, 64'd0);
        count_dones(60, nd);
        check("flush_nodone", 64'(nd), 64'd0);
        check("flush_res", {32'b0, result}, {32'b0, last_res});
        check("flush_rd", {59'b0, rd_out}, {59'b0, last_rd});

        // Flush and start together: start dropped
        @(negedge clk);
        funct3 = 3'd4; op_a = 32'd5; op_b = 32'd0; rd_in = 5'd21; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin start = 1'b0; flush = 1'b0; end
        count_dones(10, nd);
        check("flush_start_drop", 64'(nd), 64'd0);

        // Back-to-back issue in the DONE cycle
        e1 = ref_op(3'd3, 32'hdeadbeef, 32'h12345678);
        e2 = ref_op(3'd6, 32'hfffff000, 32'd37);
        issue(3'd3, 32'hdeadbeef, 32'h12345678, 5'd22);
        wait_done(cyc, fb);
        check("b2b_first_res", {32'b0, result}, {32'b0, e1});
        funct3 = 3'd6; op_a = 32'hfffff000; op_b = 32'd37; rd_in = 5'd23; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(cyc, fb);
        check("b2b_second_lat", 64'(cyc), 64'd34);
        check("b2b_second_res", {32'b0, result}, {32'b0, e2});
        check("b2b_second_rd", {59'b0, rd_out}, 64'd23);

        // UNROLL=4 divide
        e1 = ref_op(3'd4, 32'hffffff9c, 32'd7);
        @(negedge clk);
        funct3_4 = 3'd4; op_a4 = 32'hffffff9c; op_b4 = 32'd7; rd_in4 = 5'd25; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done4) break;
        end
        check("u4_div_lat", 64'(cyc), 64'd10);
        check("u4_div_res", {32'b0, result4}, {32'b0, e1});
        check("u4_div_rd", {59'b0, rd_out4}, 64'd25);

        // Reset asserted mid-CALC
        issue(3'd4, 32'd99999, 32'd13, 5'd30);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_done", {63'b0, done}, 64'd0);
        check("midrst_result", {32'b0, result}, 64'd0);
        check("midrst_rd", {59'b0, rd_out}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        count_dones(50, nd);
        check("midrst_nodone", 64'(nd), 64'd0);
        run_op("post_rst", 3'd0, 32'd12345, 32'd678, 5'd31);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
